// File: rtl/stk_pkg.sv
// Shared encodings for the multi-stack data path:
// command opcodes and the control FSM states.
package stk_pkg;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_POP  = 3'd1,
    OP_DUP  = 3'd2,
    OP_SWAP = 3'd3,
    OP_MOVE = 3'd4,
    OP_ADD  = 3'd5,
    OP_SUB  = 3'd6,
    OP_CMP  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/stack_bank.sv
// One LIFO stack: storage, pointer, top/second read ports,
// and pop/push/swap update applied in a single edge.
module stack_bank
  import stk_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       pop_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             swap_i,
  output logic [WIDTH-1:0] top_o,
  output logic [WIDTH-1:0] sec_o,
  output logic [PW-1:0]    cnt_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d, base;
  logic [AW-1:0]    t_idx, s_idx, w_idx;

  // pops are applied before the push, so the push lands on the lowest freed slot
  always_comb begin
    t_idx = AW'(ptr_q - PW'(1));
    s_idx = AW'(ptr_q - PW'(2));
    base  = ptr_q - PW'(pop_i);
    w_idx = AW'(base);
    ptr_d = base + PW'(push_i);
  end

  assign top_o   = (ptr_q >= PW'(1)) ? mem_q[t_idx] : '0;
  assign sec_o   = (ptr_q >= PW'(2)) ? mem_q[s_idx] : '0;
  assign cnt_o   = ptr_q;
  assign empty_o = (ptr_q == '0);
  assign full_o  = (ptr_q == PW'(DEPTH));

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[w_idx] <= push_data_i;
    end else if (swap_i) begin
      mem_q[t_idx] <= sec_o;
      mem_q[s_idx] <= top_o;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/multi_stack_unit.sv
// NSTK independent stacks behind one valid/ready command port;
// fixed IDLE -> READ -> WRITE sequence per command.
module multi_stack_unit
  import stk_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int NSTK  = 2,
  localparam int SW = (NSTK > 1) ? $clog2(NSTK) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [SW-1:0]    cmd_src,
  input  logic [SW-1:0]    cmd_dst,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] top,
  output logic             great,
  output logic [NSTK-1:0]  empty,
  output logic [NSTK-1:0]  full
);

  localparam int PW = $clog2(DEPTH + 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [SW-1:0]    src_q, src_d, dst_q, dst_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] st_q, st_d, ss_q, ss_d;
  logic [WIDTH-1:0] dt_q, dt_d, ds_q, ds_d;
  logic             bad_q, bad_d;
  logic             done_q, done_d, err_q, err_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic             great_q, great_d;

  logic [WIDTH-1:0] b_top [NSTK];
  logic [WIDTH-1:0] b_sec [NSTK];
  logic [PW-1:0]    b_cnt [NSTK];
  logic [1:0]       pop_v [NSTK];
  logic [NSTK-1:0]  push_v, swap_v;
  logic [WIDTH-1:0] wr_val, alu;

  logic [WIDTH-1:0] rd_st, rd_ss, rd_dt, rd_ds;
  logic [PW-1:0]    scnt, dcnt;
  logic             src_ok, dst_ok, same, dfree, legal;

  for (genvar g = 0; g < NSTK; g++) begin : g_bank
    stack_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank (
      .clk         (clk),
      .rst         (rst),
      .pop_i       (pop_v[g]),
      .push_i      (push_v[g]),
      .push_data_i (wr_val),
      .swap_i      (swap_v[g]),
      .top_o       (b_top[g]),
      .sec_o       (b_sec[g]),
      .cnt_o       (b_cnt[g]),
      .empty_o     (empty[g]),
      .full_o      (full[g])
    );
  end

  // operand mux and legality; out-of-range selects read as an empty stack
  always_comb begin
    rd_st = '0;
    rd_ss = '0;
    rd_dt = '0;
    rd_ds = '0;
    scnt  = '0;
    dcnt  = '0;
    for (int k = 0; k < NSTK; k++) begin
      if (src_q == SW'(k)) begin
        rd_st = b_top[k];
        rd_ss = b_sec[k];
        scnt  = b_cnt[k];
      end
      if (dst_q == SW'(k)) begin
        rd_dt = b_top[k];
        rd_ds = b_sec[k];
        dcnt  = b_cnt[k];
      end
    end
    src_ok = (int'(src_q) < NSTK);
    dst_ok = (int'(dst_q) < NSTK);
    same   = (src_q == dst_q);
    dfree  = (dcnt != PW'(DEPTH));
    unique case (op_q)
      OP_PUSH: legal = dst_ok && dfree;
      OP_POP:  legal = dst_ok && (dcnt >= PW'(1));
      OP_DUP:  legal = dst_ok && (dcnt >= PW'(1)) && dfree;
      OP_SWAP: legal = dst_ok && (dcnt >= PW'(2));
      OP_MOVE: legal = src_ok && dst_ok && (scnt >= PW'(1))
                       && (same || dfree);
      OP_ADD,
      OP_SUB:  legal = src_ok && dst_ok && (scnt >= PW'(2))
                       && (same || dfree);
      OP_CMP:  legal = src_ok && (scnt >= PW'(2));
      default: legal = 1'b0;
    endcase
  end

  assign alu = (op_q == OP_SUB) ? (ss_q - st_q) : (ss_q + st_q);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    st_d    = st_q;
    ss_d    = ss_q;
    dt_d    = dt_q;
    ds_d    = ds_q;
    bad_d   = bad_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    top_d   = top_q;
    great_d = great_q;
    wr_val  = '0;
    push_v  = '0;
    swap_v  = '0;
    for (int k = 0; k < NSTK; k++) pop_v[k] = 2'd0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_READ;
          op_d    = op_e'(cmd_op);
          src_d   = cmd_src;
          dst_d   = cmd_dst;
          data_d  = cmd_data;
        end
      end
      S_READ: begin
        state_d = S_WRITE;
        st_d    = rd_st;
        ss_d    = rd_ss;
        dt_d    = rd_dt;
        ds_d    = rd_ds;
        bad_d   = !legal;
      end
      S_WRITE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        err_d   = bad_q;
        top_d   = (op_q == OP_CMP) ? st_q : dt_q;
        if (!bad_q) begin
          unique case (op_q)
            OP_PUSH: begin
              wr_val        = data_q;
              push_v[dst_q] = 1'b1;
              top_d         = data_q;
            end
            OP_POP: begin
              pop_v[dst_q] = 2'd1;
              top_d        = ds_q;
            end
            OP_DUP: begin
              wr_val        = dt_q;
              push_v[dst_q] = 1'b1;
            end
            OP_SWAP: begin
              swap_v[dst_q] = 1'b1;
              top_d         = ds_q;
            end
            OP_MOVE: begin
              if (!same) begin
                pop_v[src_q]  = 2'd1;
                push_v[dst_q] = 1'b1;
                wr_val        = st_q;
                top_d         = st_q;
              end
            end
            OP_ADD,
            OP_SUB: begin
              pop_v[src_q]  = 2'd2;
              push_v[dst_q] = 1'b1;
              wr_val        = alu;
              top_d         = alu;
            end
            OP_CMP:  great_d = (ss_q > st_q);
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_PUSH;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      st_q    <= '0;
      ss_q    <= '0;
      dt_q    <= '0;
      ds_q    <= '0;
      bad_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      top_q   <= '0;
      great_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      st_q    <= st_d;
      ss_q    <= ss_d;
      dt_q    <= dt_d;
      ds_q    <= ds_d;
      bad_q   <= bad_d;
      done_q  <= done_d;
      err_q   <= err_d;
      top_q   <= top_d;
      great_q <= great_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign top       = top_q;
  assign great     = great_q;

endmodule

// File: tb/tb_multi_stack_unit.sv
// Directed bench for multi_stack_unit (WIDTH=16, DEPTH=4, NSTK=2)
// with an expectation queue popped on each done pulse.
module tb_multi_stack_unit;
  import stk_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic        cmd_src = 1'b0;
  logic        cmd_dst = 1'b0;
  logic [15:0] cmd_data = '0;
  logic        done, err, great;
  logic [15:0] top;
  logic [1:0]  empty, full;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        err;
    logic [15:0] top;
  } exp_t;

  exp_t sb[$];

  multi_stack_unit #(.WIDTH(16), .DEPTH(4), .NSTK(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_data  (cmd_data),
    .done      (done),
    .err       (err),
    .top       (top),
    .great     (great),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [2:0] op, input logic s,
                     input logic d, input logic [15:0] data,
                     input logic e_err, input logic [15:0] e_top,
                     input string tag);
    exp_t x;
    int   lat;
    @(negedge clk);
    chk({tag, ".rdy"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src   = s;
    cmd_dst   = d;
    cmd_data  = data;
    x.tag = tag;
    x.err = e_err;
    x.top = e_top;
    sb.push_back(x);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, lat, 2);
    x = sb.pop_front();
    chk({x.tag, ".err"}, err, x.err);
    chk({x.tag, ".top"}, top, x.top);
  endtask

  initial begin
    int acc;
    int dn;
    logic [8:0] amask;

    repeat (2) @(negedge clk);
    chk("rst.rdy", cmd_ready, 1);
    chk("rst.empty", empty, 2'b11);
    chk("rst.full", full, 2'b00);
    chk("rst.top", top, 0);
    chk("rst.done", done, 0);
    chk("rst.great", great, 0);
    rst = 1'b1;

    // reset lands while a push is in flight: it must vanish
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_PUSH;
    cmd_dst   = 1'b0;
    cmd_data  = 16'h0007;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid.rdy", cmd_ready, 1);
    chk("mid.empty", empty, 2'b11);
    chk("mid.full", full, 2'b00);
    chk("mid.top", top, 0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    chk("mid.nodone", dn, 0);
    rst = 1'b1;

    cmd(OP_PUSH, 0, 0, 16'd9, 0, 16'd9, "push9");
    cmd(OP_PUSH, 0, 0, 16'd5, 0, 16'd5, "push5");
    cmd(OP_SUB,  0, 1, 16'd0, 0, 16'd4, "sub");
    chk("sub.empty", empty, 2'b01);

    cmd(OP_POP,  0, 1, 16'd0, 0, 16'd0, "pop1");
    cmd(OP_PUSH, 0, 1, 16'd10, 0, 16'd10, "p1a");
    cmd(OP_PUSH, 0, 1, 16'd11, 0, 16'd11, "p1b");
    cmd(OP_PUSH, 0, 1, 16'd12, 0, 16'd12, "p1c");
    cmd(OP_PUSH, 0, 1, 16'd13, 0, 16'd13, "p1d");
    chk("s1.full", full, 2'b10);
    cmd(OP_PUSH, 0, 1, 16'd14, 1, 16'd13, "ovf");
    chk("ovf.full", full, 2'b10);
    cmd(OP_POP,  0, 1, 16'd0, 0, 16'd12, "pop1b");

    cmd(OP_POP,  0, 0, 16'd0, 1, 16'd0, "unf");
    cmd(OP_PUSH, 0, 0, 16'd1, 0, 16'd1, "p0a");
    cmd(OP_ADD,  0, 0, 16'd0, 1, 16'd1, "add1");
    chk("add1.empty", empty, 2'b00);
    cmd(OP_PUSH, 0, 0, 16'd2, 0, 16'd2, "p0b");
    cmd(OP_PUSH, 0, 0, 16'd3, 0, 16'd3, "p0c");
    cmd(OP_PUSH, 0, 0, 16'd4, 0, 16'd4, "p0d");
    chk("s0.full", full, 2'b01);
    cmd(OP_ADD,  0, 0, 16'd0, 0, 16'd7, "addff");
    chk("addff.full", full, 2'b00);
    cmd(OP_CMP,  0, 0, 16'd0, 0, 16'd7, "cmp0");
    chk("cmp0.great", great, 0);
    cmd(OP_SWAP, 0, 0, 16'd0, 0, 16'd2, "swap");
    cmd(OP_CMP,  0, 0, 16'd0, 0, 16'd2, "cmp1");
    chk("cmp1.great", great, 1);

    cmd(OP_MOVE, 0, 1, 16'd0, 0, 16'd2, "mv01");
    chk("mv01.full", full, 2'b10);
    cmd(OP_MOVE, 1, 1, 16'd0, 0, 16'd2, "mv11");
    cmd(OP_MOVE, 0, 1, 16'd0, 1, 16'd2, "mvovf");
    chk("hold.great", great, 1);
    cmd(OP_DUP,  0, 0, 16'd0, 0, 16'd7, "dup");
    cmd(OP_POP,  0, 0, 16'd0, 0, 16'd7, "pa");
    cmd(OP_POP,  0, 0, 16'd0, 0, 16'd1, "pb");
    cmd(OP_POP,  0, 0, 16'd0, 0, 16'd0, "pc");
    chk("pc.empty", empty, 2'b01);

    cmd(OP_PUSH, 0, 0, 16'hFFFF, 0, 16'hFFFF, "pff");
    cmd(OP_PUSH, 0, 0, 16'h0002, 0, 16'h0002, "p02");
    cmd(OP_ADD,  0, 0, 16'd0, 0, 16'h0001, "wrap");

    // cmd_valid held high for nine cycles
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_PUSH;
    cmd_dst   = 1'b0;
    cmd_data  = 16'h0020;
    acc   = 0;
    dn    = 0;
    amask = '0;
    for (int i = 0; i < 9; i++) begin
      if (cmd_ready === 1'b1) begin
        acc++;
        amask[i] = 1'b1;
      end
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (done === 1'b1) dn++;
    chk("b2b.acc", acc, 3);
    chk("b2b.mask", amask, 9'b001001001);
    chk("b2b.done", dn, 3);
    chk("b2b.top", top, 16'h0020);
    chk("b2b.full", full, 2'b11);
    cmd(OP_PUSH, 0, 0, 16'd99, 1, 16'h0020, "ovf0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
